twos_complement_serial: RTL and testbench
=========================================

Name: twos_complement_serial

Overview:
- Parametrised, digit-serial two's-complement sign unit for the floating-point adder datapath.
- Successor to the fixed 8-bit combinational negator.
- Processes DIGIT bits per cycle, LSB first, with one carry register.
- Supports pass, negate, absolute value and negative absolute value.
- Uses valid/ready handshakes on input and output so it can sit between the mantissa align stage and the adder core.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- DIGIT, 2, bits processed per cycle; must satisfy 1 <= DIGIT <= WIDTH and divide WIDTH exactly, otherwise elaboration fails. N = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  signed operand.
- in_mode  in  2  00 pass, 01 negate, 10 abs, 11 negative abs (-|x|).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  signed result.
- out_neg  out  1  negation was applied to this operand.
- out_ovf  out  1  result not representable (negating the most negative value).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. rst overrides every other input on the same edge.
- Reset state:
  - state=IDLE, counter=0, carry=0.
  - out_valid=0, out_data=0, out_neg=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_data into the operand shift register, compute neg, set carry=neg, counter=0, go to BUSY.
  - neg rules:
    - mode 00: 0
    - mode 01: 1
    - mode 10: in_data[WIDTH-1]
    - mode 11: ~in_data[WIDTH-1]
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, take the low DIGIT operand bits d and compute s = (d ^ {DIGIT{neg}}) + carry, DIGIT+1 bits wide.
  - Shift s[DIGIT-1:0] into the result register from the MSB end; carry = s[DIGIT]; shift the operand right by DIGIT.
  - counter increments each cycle. On counter==N-1, go to DONE.
  - BUSY lasts exactly N cycles.
  - The final carry is discarded.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data = completed result register.
  - out_neg = neg.
  - out_ovf = neg && operand == {1'b1,{WIDTH-1{1'b0}}}. For that operand out_data equals the input (0x80 -> 0x80 at WIDTH=8).
  - On out_valid&&out_ready, go to IDLE.
  - While out_ready=0, out_data, out_neg and out_ovf hold stable.
- Latency and throughput:
  - If the operand is accepted at edge E0, out_valid is high after edge E0+N.
  - The earliest next acceptance is the cycle after the output transfer.
  - Peak throughput is one operand per N+2 cycles.
- Boundary cases:
  - in_valid outside IDLE is ignored; no buffering.
  - Zero input with neg=1 gives 0, out_neg=1, out_ovf=0.
  - Mode 11 never sets ovf.
  - DIGIT==WIDTH gives N=1: one BUSY cycle.
  - DIGIT=1 gives a bit-serial unit.
  - rst in BUSY or DONE abandons the transaction. No out_valid is produced for it, and IDLE is entered with in_ready=1 on the next cycle.
  - Outputs are registered. The only combinational outputs are in_ready and out_valid, decoded from state.

Test Plan (WIDTH=8, DIGIT=2, N=4 unless stated):
- Negate: mode 01, in_data 0x05 -> out_data 0xFB, out_neg=1, out_ovf=0, out_valid exactly 4 edges after acceptance.
- Edge values: negate 0x80 -> 0x80, out_ovf=1; negate 0x00 -> 0x00, out_neg=1, out_ovf=0; pass 0x80 -> 0x80, out_ovf=0.
- Modes: abs 0xF6 -> 0x0A, out_neg=1; abs 0x37 -> 0x37, out_neg=0; mode 11 0x37 -> 0xC9, out_neg=1; mode 11 0xF6 -> 0xF6, out_neg=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0; in_valid pulses with 0x11 are ignored; the result transfers when out_ready rises; IDLE follows on the next cycle.
- Reset mid-operation: assert rst in the 2nd BUSY cycle -> no out_valid for that operand; in_ready=1 the next cycle; a following negate of 0x01 -> 0xFF correct.
- Parameter sweep: WIDTH=16 with DIGIT=1, 4 and 16 -> 1000 random operands and modes each, checked against a reference model for data, neg and ovf, with latency N.

Source files
------------

// File: rtl/twos_complement_serial.sv
// Digit-serial two's-complement sign unit: pass, negate, abs and -|x|.
// The operand is walked LSB first, DIGIT bits per cycle, with a single carry
// flop; a valid/ready pair on each side lets it sit between pipeline stages.
module twos_complement_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_neg,
    output logic             out_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST_DIGIT = CW'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // Refuse to build with a digit size that does not tile the operand.
    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("twos_complement_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [WIDTH-1:0]  res_q, res_d;

    // One digit of conditional invert-and-increment: ~x + 1 spread over N cycles,
    // with the +1 injected as the initial carry.
    logic [DIGIT-1:0]  digit_x;
    logic [DIGIT:0]    digit_sum;
    logic [WIDTH-1:0]  res_shift;
    logic [WIDTH-1:0]  op_shift;

    assign digit_x   = op_q[DIGIT-1:0] ^ {DIGIT{neg_q}};
    assign digit_sum = {1'b0, digit_x} + {{DIGIT{1'b0}}, carry_q};

    // New result digits enter at the MSB end so that after N shifts the first
    // (least significant) digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign res_shift = digit_sum[DIGIT-1:0];
            assign op_shift  = '0;
        end else begin : g_multi_digit
            assign res_shift = {digit_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
            assign op_shift  = {{DIGIT{1'b0}}, op_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Handshake signals are pure state decodes; everything else is registered.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_neg   = neg_q;
    assign out_ovf   = ovf_q;

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: accept in IDLE, crunch N digits in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (in_mode)
                        2'b00:   neg_d = 1'b0;
                        2'b01:   neg_d = 1'b1;
                        2'b10:   neg_d = in_data[WIDTH-1];
                        default: neg_d = ~in_data[WIDTH-1];
                    endcase
                    carry_d = neg_d;
                    // Only the most negative value has no positive counterpart.
                    ovf_d   = neg_d && (in_data == MOST_NEG);
                    cnt_d   = '0;
                    op_d    = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d   = res_shift;
                op_d    = op_shift;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: directed cases on an 8/2 instance, then
// random traffic on 8/2 plus 16-bit instances with DIGIT 1, 4 and 16, all
// compared every cycle against an arithmetic reference model.
module tb_twos_complement_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [4];
    logic        in_valid  [4];
    logic [15:0] in_data   [4];
    logic [1:0]  in_mode   [4];
    logic        out_ready [4];

    logic [3:0]  in_ready_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  out_neg_v;
    logic [3:0]  out_ovf_v;
    logic [7:0]  od0;
    logic [15:0] od1, od2, od3;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: 0 idle, 1 busy, 2 done.
    int          mst   [4];
    int          mleft [4];
    bit          mvalid[4];
    bit          mjr   [4];
    logic [15:0] mexp  [4];
    logic        mneg  [4];
    logic        movf  [4];
    int          acc   [4];
    int          done_cnt[4];

    twos_complement_serial #(.WIDTH(8), .DIGIT(2)) dut_w8_d2 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data[0][7:0]), .in_mode(in_mode[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready[0]), .out_data(od0), .out_neg(out_neg_v[0]), .out_ovf(out_ovf_v[0]));

    twos_complement_serial #(.WIDTH(16), .DIGIT(1)) dut_w16_d1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready[1]), .out_data(od1), .out_neg(out_neg_v[1]), .out_ovf(out_ovf_v[1]));

    twos_complement_serial #(.WIDTH(16), .DIGIT(4)) dut_w16_d4 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready[2]), .out_data(od2), .out_neg(out_neg_v[2]), .out_ovf(out_ovf_v[2]));

    twos_complement_serial #(.WIDTH(16), .DIGIT(16)) dut_w16_d16 (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready_v[3]),
        .in_data(in_data[3]), .in_mode(in_mode[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready[3]), .out_data(od3), .out_neg(out_neg_v[3]), .out_ovf(out_ovf_v[3]));

    function automatic int wof(int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic int nof(int k);
        case (k)
            0:       return 4;
            1:       return 16;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] mask_w(int w);
        return (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [15:0] get_od(int k);
        case (k)
            0:       return {8'h00, od0};
            1:       return od1;
            2:       return od2;
            default: return od3;
        endcase
    endfunction

    function automatic logic model_neg(int w, logic [1:0] mode, logic [15:0] x);
        logic sign;
        sign = x[w-1];
        case (mode)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return sign;
            default: return ~sign;
        endcase
    endfunction

    function automatic logic [15:0] model_res(int w, logic [1:0] mode, logic [15:0] x);
        logic [15:0] xm;
        xm = x & mask_w(w);
        if (model_neg(w, mode, xm)) return (16'd0 - xm) & mask_w(w);
        return xm;
    endfunction

    function automatic logic model_ovf(int w, logic [1:0] mode, logic [15:0] x);
        logic [15:0] xm;
        xm = x & mask_w(w);
        return model_neg(w, mode, xm) && (xm == 16'(32'd1 << (w - 1)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model with the
    // inputs the DUT will sample on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (mvalid[k]) begin
                    chk($sformatf("i%0d_in_ready", k), 32'(in_ready_v[k]), 32'(mst[k] == 0));
                    chk($sformatf("i%0d_out_valid", k), 32'(out_valid_v[k]), 32'(mst[k] == 2));
                    if (mst[k] == 2) begin
                        chk($sformatf("i%0d_out_data", k), 32'(get_od(k)), 32'(mexp[k]));
                        chk($sformatf("i%0d_out_neg", k), 32'(out_neg_v[k]), 32'(mneg[k]));
                        chk($sformatf("i%0d_out_ovf", k), 32'(out_ovf_v[k]), 32'(movf[k]));
                    end
                    if (mjr[k]) begin
                        chk($sformatf("i%0d_rst_data", k), 32'(get_od(k)), 32'd0);
                        chk($sformatf("i%0d_rst_neg", k), 32'(out_neg_v[k]), 32'd0);
                        chk($sformatf("i%0d_rst_ovf", k), 32'(out_ovf_v[k]), 32'd0);
                    end
                end
                mjr[k] = 1'b0;
                if (rst[k] === 1'b1) begin
                    mvalid[k] = 1'b1;
                    mst[k]    = 0;
                    mjr[k]    = 1'b1;
                end else if (mvalid[k]) begin
                    case (mst[k])
                        0: if (in_valid[k]) begin
                            mexp[k]  = model_res(wof(k), in_mode[k], in_data[k]);
                            mneg[k]  = model_neg(wof(k), in_mode[k], in_data[k] & mask_w(wof(k)));
                            movf[k]  = model_ovf(wof(k), in_mode[k], in_data[k]);
                            mst[k]   = 1;
                            mleft[k] = nof(k);
                            acc[k]++;
                        end
                        1: begin
                            mleft[k]--;
                            if (mleft[k] == 0) mst[k] = 2;
                        end
                        default: if (out_ready[k]) begin
                            mst[k] = 0;
                            done_cnt[k]++;
                        end
                    endcase
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One directed operation on the 8/2 instance with literal expectations.
    task automatic do_op(string name, logic [1:0] mode, logic [7:0] x,
                         logic [7:0] e_data, logic e_neg, logic e_ovf, bit hold);
        int w;
        int lat;
        w = 0;
        while (in_ready_v[0] !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk({name, "_ready"}, 32'(in_ready_v[0]), 32'd1);
        in_valid[0]  = 1'b1;
        in_data[0]   = {8'h00, x};
        in_mode[0]   = mode;
        out_ready[0] = !hold;
        step();
        in_valid[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_data"}, 32'(od0), 32'(e_data));
        chk({name, "_neg"}, 32'(out_neg_v[0]), 32'(e_neg));
        chk({name, "_ovf"}, 32'(out_ovf_v[0]), 32'(e_ovf));
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 4; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_mode[k]   = 2'b00;
            out_ready[k] = 1'b1;
        end
        step();
        step();
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Hand-computed values pinning the reference model.
        chk("model_neg_05", 32'(model_res(8, 2'b01, 16'h0005)), 32'h00FB);
        chk("model_abs_fff6", 32'(model_res(16, 2'b10, 16'hFFF6)), 32'h000A);
        chk("model_ovf_8000", 32'(model_ovf(16, 2'b01, 16'h8000)), 32'd1);
        chk("model_nabs_80", 32'(model_ovf(8, 2'b11, 16'h0080)), 32'd0);

        do_op("neg_05",  2'b01, 8'h05, 8'hFB, 1'b1, 1'b0, 1'b0);
        do_op("neg_80",  2'b01, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        do_op("neg_00",  2'b01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("pass_80", 2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op("abs_f6",  2'b10, 8'hF6, 8'h0A, 1'b1, 1'b0, 1'b0);
        do_op("abs_37",  2'b10, 8'h37, 8'h37, 1'b0, 1'b0, 1'b0);
        do_op("nabs_37", 2'b11, 8'h37, 8'hC9, 1'b1, 1'b0, 1'b0);
        do_op("nabs_f6", 2'b11, 8'hF6, 8'hF6, 1'b0, 1'b0, 1'b0);

        // Backpressure: result must hold while stray operands are ignored.
        do_op("bp_22", 2'b01, 8'h22, 8'hDE, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 16'h0011;
            in_mode[0]  = 2'b01;
            step();
            chk("bp_hold_data", 32'(od0), 32'h00DE);
            chk("bp_hold_in_ready", 32'(in_ready_v[0]), 32'd0);
            chk("bp_hold_out_valid", 32'(out_valid_v[0]), 32'd1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        step();
        chk("bp_release_out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready_v[0]), 32'd1);
        step();
        chk("bp_no_buffer_in_ready", 32'(in_ready_v[0]), 32'd1);

        // Reset during the second BUSY cycle abandons the operand.
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h0005;
        in_mode[0]  = 2'b01;
        step();
        in_valid[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
        chk("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("midrst_out_data", 32'(od0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_no_valid", 32'(out_valid_v[0]), 32'd0);
        end
        do_op("after_rst_neg_01", 2'b01, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Random sweep on all instances, occasionally hitting edge operands and reset.
        cyc = 0;
        while ((acc[0] < 300 || acc[1] < 1000 || acc[2] < 1000 || acc[3] < 1000) && cyc < 90000) begin
            for (int k = 0; k < 4; k++) begin
                if (acc[k] < ((k == 0) ? 300 : 1000)) begin
                    in_valid[k] = ($urandom_range(3) != 0);
                    case ($urandom_range(7))
                        0:       in_data[k] = 16'(32'd1 << (wof(k) - 1));
                        1:       in_data[k] = 16'h0000;
                        default: in_data[k] = 16'($urandom) & mask_w(wof(k));
                    endcase
                    in_mode[k]   = 2'($urandom_range(3));
                    out_ready[k] = ($urandom_range(3) != 0);
                    rst[k]       = ($urandom_range(499) == 0);
                end else begin
                    in_valid[k]  = 1'b0;
                    out_ready[k] = 1'b1;
                    rst[k]       = 1'b0;
                end
            end
            step();
            cyc++;
        end
        chk("sweep_within_budget", 32'(cyc < 90000), 32'd1);
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            rst[k]       = 1'b0;
        end
        repeat (20) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("i%0d_results_seen", k), 32'(done_cnt[k] > 0), 32'd1);
        end
        chk("drain_all_idle", 32'(in_ready_v), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
